// File: rtl/matmul_pkg.sv
// Shared definitions for param_matrix_multiplier: FSM state encoding and the
// index/accumulator width helpers used to size the datapath.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } mm_state_e;

    function automatic int idx_width(input int m, input int k, input int n);
        int mx;
        mx = (m > k) ? m : k;
        mx = (mx > n) ? mx : n;
        return ($clog2(mx) > 32'sd1) ? $clog2(mx) : 32'sd1;
    endfunction

    // Wide enough that K full-scale products can never overflow.
    function automatic int acc_width(input int dw, input int k);
        return 32'sd2 * dw + $clog2(k) + 32'sd1;
    endfunction

endpackage

// File: rtl/param_matrix_multiplier_if.sv
// Operand-fetch, result-stream and status bundle of param_matrix_multiplier.
interface param_matrix_multiplier_if #(
    parameter int DW = 32,
    parameter int IW = 2
);
    logic          start;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic [IW-1:0] a_i;
    logic [IW-1:0] a_j;
    logic [IW-1:0] b_i;
    logic [IW-1:0] b_j;
    logic [DW-1:0] z_out;
    logic [IW-1:0] z_i;
    logic [IW-1:0] z_j;
    logic          z_stb;
    logic          z_ack;
    logic          busy;
    logic          done;

    modport slave (
        input  start, a_in, b_in, z_ack,
        output a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb, busy, done
    );

    modport master (
        output start, a_in, b_in, z_ack,
        input  a_i, a_j, b_i, b_j, z_out, z_i, z_j, z_stb, busy, done
    );
endinterface

// File: rtl/matmul_mac_unit.sv
// Signed multiply-accumulate with clear/enable; the registered result is reduced
// to DW bits by wrap, or by saturation when PARAM_MATRIX_MULTIPLIER_SAT_EN is defined.
module matmul_mac_unit #(
    parameter int DW = 32,
    parameter int AW = 2 * DW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_last,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_z
);
    localparam int PW = 2 * DW;

`ifdef PARAM_MATRIX_MULTIPLIER_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_acc_nxt;
    logic signed [AW-1:0] r_acc;
    logic [DW-1:0]        r_z;

    function automatic logic [DW-1:0] reduce(input logic signed [AW-1:0] acc);
`ifdef PARAM_MATRIX_MULTIPLIER_SAT_EN
        logic [DW-1:0] v;
        if (acc > SAT_MAX) begin
            v = SAT_MAX[DW-1:0];
        end else if (acc < SAT_MIN) begin
            v = SAT_MIN[DW-1:0];
        end else begin
            v = acc[DW-1:0];
        end
        return v;
`else
        return acc[DW-1:0];
`endif
    endfunction

    assign w_prod    = PW'($signed(i_a)) * PW'($signed(i_b));
    assign w_acc_nxt = r_acc + AW'(w_prod);
    assign o_z       = r_z;

    // Accumulator and the reduced result captured on the last product of an element.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_z   <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_z   <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_nxt;
            if (i_last) begin
                r_z <= reduce(w_acc_nxt);
            end
        end
    end

endmodule

// File: rtl/param_matrix_multiplier.sv
// Z = A x B sequencer: walks i/j/k, fetches operands through registered index
// ports and streams Z row-major on z_stb/z_ack. Saturating reduce is selected
// by PARAM_MATRIX_MULTIPLIER_SAT_EN (wrap when undefined).
module param_matrix_multiplier
    import matmul_pkg::*;
#(
    parameter int M  = 4,
    parameter int K  = 4,
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int IW = idx_width(M, K, N),
    parameter int AW = acc_width(DW, K)
) (
    input  logic                      clk,
    input  logic                      rst,
    param_matrix_multiplier_if.slave  bus
);
    localparam logic [IW-1:0] K_LAST = IW'(K - 1);
    localparam logic [IW-1:0] N_LAST = IW'(N - 1);
    localparam logic [IW-1:0] M_LAST = IW'(M - 1);

    mm_state_e     r_state, w_state_nxt;
    logic [IW-1:0] r_i, r_j, r_k;
    logic [IW-1:0] w_i_nxt, w_j_nxt, w_k_nxt;
    logic          w_clr, w_en, w_last;
    logic [IW-1:0] r_idx_i, r_idx_k, r_idx_j;
    logic [IW-1:0] r_z_i, r_z_j;
    logic          r_z_stb, r_busy, r_done;
    logic [DW-1:0] w_z;

    matmul_mac_unit #(.DW(DW), .AW(AW)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .i_last (w_last),
        .i_a    (bus.a_in),
        .i_b    (bus.b_in),
        .o_z    (w_z)
    );

    // State and loop-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Next-state, counter advance and MAC control.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                    w_clr       = 1'b1;
                    w_state_nxt = ST_MAC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MAC: begin
                w_en = 1'b1;
                if (r_k == K_LAST) begin
                    w_k_nxt     = '0;
                    w_last      = 1'b1;
                    w_state_nxt = ST_OUT;
                end else begin
                    w_k_nxt = r_k + IW'(1);
                end
            end
            ST_OUT: begin
                // z_stb is high exactly while in OUT, so ack here is a transfer.
                if (bus.z_ack) begin
                    w_clr = 1'b1;
                    if (r_j < N_LAST) begin
                        w_j_nxt     = r_j + IW'(1);
                        w_state_nxt = ST_MAC;
                    end else if (r_i < M_LAST) begin
                        w_j_nxt     = '0;
                        w_i_nxt     = r_i + IW'(1);
                        w_state_nxt = ST_MAC;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_DONE: begin
                if (!bus.start) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output registers are loaded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx_i <= '0;
            r_idx_k <= '0;
            r_idx_j <= '0;
            r_z_i   <= '0;
            r_z_j   <= '0;
            r_z_stb <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_idx_i <= (w_state_nxt == ST_MAC) ? w_i_nxt : '0;
            r_idx_k <= (w_state_nxt == ST_MAC) ? w_k_nxt : '0;
            r_idx_j <= (w_state_nxt == ST_MAC) ? w_j_nxt : '0;
            r_z_i   <= (w_state_nxt == ST_OUT) ? w_i_nxt : '0;
            r_z_j   <= (w_state_nxt == ST_OUT) ? w_j_nxt : '0;
            r_z_stb <= (w_state_nxt == ST_OUT);
            r_busy  <= (w_state_nxt == ST_MAC) || (w_state_nxt == ST_OUT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.a_i   = r_idx_i;
    assign bus.a_j   = r_idx_k;
    assign bus.b_i   = r_idx_k;
    assign bus.b_j   = r_idx_j;
    assign bus.z_out = w_z;
    assign bus.z_i   = r_z_i;
    assign bus.z_j   = r_z_j;
    assign bus.z_stb = r_z_stb;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_param_matrix_multiplier.sv
// Scoreboard bench for param_matrix_multiplier: a 4x4x4/DW=32 instance and a
// 2x3x2/DW=8 instance, each checked against an arithmetic reference model.
module tb_param_matrix_multiplier;

    typedef struct {
        int          i;
        int          j;
        logic [31:0] z;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   slow_i = -1, slow_j = -1, slow_hold = 0;
    bit   stray_en = 1'b0, rand_ack = 1'b0;

    exp_t q0[$];
    exp_t q1[$];

    logic [31:0] a0 [0:3][0:3];
    logic [31:0] b0 [0:3][0:3];
    logic [7:0]  a1 [0:3][0:3];
    logic [7:0]  b1 [0:3][0:3];

    always #5 clk = ~clk;

    param_matrix_multiplier_if #(.DW(32), .IW(2)) if0 ();
    param_matrix_multiplier_if #(.DW(8),  .IW(2)) if1 ();

    param_matrix_multiplier #(.M(4), .K(4), .N(4), .DW(32)) u_dut0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    param_matrix_multiplier #(.M(2), .K(3), .N(2), .DW(8)) u_dut1 (
        .clk (clk), .rst (rst), .bus (if1)
    );

    assign if0.a_in = a0[if0.a_i][if0.a_j];
    assign if0.b_in = b0[if0.b_i][if0.b_j];
    assign if1.a_in = a1[if1.a_i][if1.a_j];
    assign if1.b_in = b1[if1.b_i][if1.b_j];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: exact integer sum of products, then wrap or clamp to dw bits.
    function automatic longint sx(input logic [31:0] v, input int dw);
        longint r;
        r = longint'(v) & ((64'sd1 <<< dw) - 64'sd1);
        if (r >= (64'sd1 <<< (dw - 1))) r = r - (64'sd1 <<< dw);
        return r;
    endfunction

    function automatic logic [31:0] reduce_m(input longint s, input int dw);
        longint      r;
        logic [63:0] t;
        r = s;
`ifdef PARAM_MATRIX_MULTIPLIER_SAT_EN
        if (s > (64'sd1 <<< (dw - 1)) - 64'sd1) r = (64'sd1 <<< (dw - 1)) - 64'sd1;
        else if (s < -(64'sd1 <<< (dw - 1))) r = -(64'sd1 <<< (dw - 1));
`endif
        t = r & ((64'sd1 <<< dw) - 64'sd1);
        return t[31:0];
    endfunction

    function automatic logic [31:0] rnd32();
        int t;
        t = $urandom;
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 20)) - 32'd10;
        t = t >>> 2;
        return t;
    endfunction

    task automatic push0();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                longint s = 0;
                for (int k = 0; k < 4; k++) s += sx(a0[i][k], 32) * sx(b0[k][j], 32);
                q0.push_back('{i, j, reduce_m(s, 32)});
            end
    endtask

    task automatic push1();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                longint s = 0;
                for (int k = 0; k < 3; k++) s += sx(32'(a1[i][k]), 8) * sx(32'(b1[k][j]), 8);
                q1.push_back('{i, j, reduce_m(s, 8)});
            end
    endtask

    task automatic rand0();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a0[i][j] = rnd32();
                b0[i][j] = rnd32();
            end
    endtask

    task automatic wait_done(input int which);
        int c = 0;
        while (c < 3000 && !((which == 0) ? if0.done : if1.done)) begin
            @(negedge clk);
            c++;
        end
        if (which == 0) begin
            check("done0", if0.done, 1);
            check("busy0_at_done", if0.busy, 0);
            check("q0_drained", q0.size(), 0);
        end else begin
            check("done1", if1.done, 1);
            check("q1_drained", q1.size(), 0);
        end
    endtask

    task automatic run0();
        push0();
        if0.start = 1'b1;
        wait_done(0);
        if0.start = 1'b0;
        @(negedge clk);
        check("idle0_done", if0.done, 0);
    endtask

    task automatic run1();
        push1();
        if1.start = 1'b1;
        wait_done(1);
        if1.start = 1'b0;
        @(negedge clk);
        check("idle1_done", if1.done, 0);
    endtask

    // Consumer for instance 0: registered, random, per-element delayed and stray acks.
    initial begin : cons0
        int hc = 0;
        if0.z_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if0.z_ack = 1'b0;
                hc = 0;
            end else if (if0.z_ack) begin
                if0.z_ack = 1'b0;
            end else if (if0.z_stb) begin
                if (int'(if0.z_i) == slow_i && int'(if0.z_j) == slow_j) begin
                    if (hc >= slow_hold) begin
                        if0.z_ack = 1'b1;
                        hc = 0;
                    end else begin
                        hc++;
                    end
                end else if (!rand_ack || $urandom_range(0, 1) == 1) begin
                    if0.z_ack = 1'b1;
                end
            end else if (stray_en && $urandom_range(0, 2) == 0) begin
                if0.z_ack = 1'b1;
            end
        end
    end

    initial begin : cons1
        if1.z_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst || if1.z_ack) if1.z_ack = 1'b0;
            else if (if1.z_stb) if1.z_ack = 1'b1;
        end
    end

    // Monitor 0: hold-stability while stalled, then scoreboard compare on transfer.
    initial begin : mon0
        logic        p_stb = 1'b0, p_x = 1'b0;
        logic [31:0] p_z = '0;
        logic [1:0]  p_i = '0, p_j = '0;
        int          cyc = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p_stb = 1'b0;
                p_x   = 1'b0;
                cyc   = 0;
            end else begin
                if (p_stb && !p_x) begin
                    check("hold0_stb", if0.z_stb, 1);
                    if (if0.z_stb) begin
                        check("hold0_z", if0.z_out, p_z);
                        check("hold0_ij", {if0.z_i, if0.z_j}, {p_i, p_j});
                    end
                end
                cyc = if0.z_stb ? cyc + 1 : 0;
                p_x = if0.z_stb && if0.z_ack;
                if (p_x) begin
                    if (q0.size() == 0) begin
                        check("unexpected0_stb", if0.z_stb, 0);
                    end else begin
                        e = q0.pop_front();
                        check("z0_ij", {if0.z_i, if0.z_j}, {e.i[1:0], e.j[1:0]});
                        check("z0_val", if0.z_out, e.z);
                        if (e.i == slow_i && e.j == slow_j)
                            check("slow0_held", cyc >= slow_hold + 1, 1);
                    end
                end
                p_stb = if0.z_stb;
                p_z   = if0.z_out;
                p_i   = if0.z_i;
                p_j   = if0.z_j;
            end
        end
    end

    initial begin : mon1
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && if1.z_stb && if1.z_ack) begin
                if (q1.size() == 0) begin
                    check("unexpected1_stb", if1.z_stb, 0);
                end else begin
                    e = q1.pop_front();
                    check("z1_ij", {if1.z_i, if1.z_j}, {e.i[1:0], e.j[1:0]});
                    check("z1_val", if1.z_out, e.z);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin : stim
        int  c;
        bit  hit;
        rst = 1'b0;
        if0.start = 1'b0;
        if1.start = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a0[i][j] = '0; b0[i][j] = '0; a1[i][j] = '0; b1[i][j] = '0;
            end
        repeat (3) @(negedge clk);
        check("rst0_stb", if0.z_stb, 0);
        check("rst0_busy", if0.busy, 0);
        check("rst0_done", if0.done, 0);
        check("rst0_zout", if0.z_out, 0);
        check("rst0_idx", {if0.a_i, if0.a_j, if0.b_i, if0.b_j, if0.z_i, if0.z_j}, 0);
        check("rst1_busy_done", {if1.busy, if1.done, if1.z_stb}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Identity A, B[i][j] = 4i+j.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a0[i][j] = (i == j) ? 32'd1 : 32'd0;
                b0[i][j] = 32'(4 * i + j);
            end
        run0();

        rand_ack = 1'b1;
        stray_en = 1'b1;
        repeat (2) begin
            rand0();
            run0();
        end

        rand_ack  = 1'b0;
        slow_i    = 1;
        slow_j    = 2;
        slow_hold = 5;
        rand0();
        run0();
        slow_i   = -1;
        slow_j   = -1;
        stray_en = 1'b0;

        // Reset during the third MAC cycle of element (0,1), start held.
        rand0();
        push0();
        if0.start = 1'b1;
        c   = 0;
        hit = 1'b0;
        while (c < 500 && !hit) begin
            @(negedge clk);
            c++;
            hit = if0.busy && !if0.z_stb && if0.a_i == 2'd0 && if0.b_j == 2'd1 && if0.a_j == 2'd2;
        end
        check("rst_trigger0", hit, 1);
        rst = 1'b0;
        #1;
        check("midrst_stb", if0.z_stb, 0);
        check("midrst_busy_done", {if0.busy, if0.done}, 0);
        check("midrst_zout", if0.z_out, 0);
        check("midrst_idx", {if0.a_i, if0.a_j, if0.b_i, if0.b_j, if0.z_i, if0.z_j}, 0);
        q0.delete();
        push0();
        @(negedge clk);
        rst = 1'b1;
        wait_done(0);

        // start still held after done: no restart until it drops.
        repeat (10) begin
            @(negedge clk);
            check("held_done", if0.done, 1);
            check("held_stb", {if0.z_stb, if0.busy}, 0);
        end
        if0.start = 1'b0;
        @(negedge clk);
        check("drop_done", if0.done, 0);
        check("drop_busy", if0.busy, 0);
        rand0();
        run0();

        // 2x3x2 at DW=8.
        a1[0][0] = 8'd1; a1[0][1] = 8'd2; a1[0][2] = 8'd3;
        a1[1][0] = 8'd4; a1[1][1] = 8'd5; a1[1][2] = 8'd6;
        b1[0][0] = 8'd7;  b1[0][1] = 8'd8;
        b1[1][0] = 8'd9;  b1[1][1] = 8'd10;
        b1[2][0] = 8'd11; b1[2][1] = 8'd12;
        run1();

        // +/-20000 at DW=8: wraps to 0x20/0xE0, saturates to 0x7F/0x80.
        a1[0][0] = 8'd100;  a1[0][1] = 8'd100;  a1[0][2] = 8'd0;
        a1[1][0] = 8'h9C;   a1[1][1] = 8'h9C;   a1[1][2] = 8'd0;
        b1[0][0] = 8'd100;  b1[0][1] = 8'd100;
        b1[1][0] = 8'd100;  b1[1][1] = 8'd100;
        b1[2][0] = 8'd0;    b1[2][1] = 8'd0;
        run1();

        repeat (3) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    a1[i][j] = 8'($urandom);
                    b1[i][j] = 8'($urandom);
                end
            run1();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/param_matrix_multiplier.md
Name: param_matrix_multiplier

Overview:
- Computes Z = A x B for an MxK matrix A and a KxN matrix B, with signed integer elements of DW bits. Successor to the fixed 4x4 sequential multiplier, generalised to rectangular shapes, parametrised width and a wide accumulator.
- Fetches operands from external, combinationally-indexed storage through index ports. Streams each Z element out on a z_stb/z_ack handshake in row-major order.
- Signals completion with `done`.

Parameters:
- M, 4, rows of A and Z.
- K, 4, columns of A / rows of B (inner dimension), >=1.
- N, 4, columns of B and Z.
- DW, 32, element width of A, B and Z.
- IW, max(1,$clog2(max(M,K,N))), width of every index port.
- AW, 2*DW+$clog2(K)+1, internal accumulator width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level request; sampled in IDLE only.
- a_in  in  DW  A[a_i][a_j], combinational from storage.
- b_in  in  DW  B[b_i][b_j], combinational from storage.
- a_i, a_j  out  IW  A read index (registered).
- b_i, b_j  out  IW  B read index (registered).
- z_out  out  DW  result element.
- z_i, z_j  out  IW  result element index.
- z_stb  out  1  z_out/z_i/z_j valid.
- z_ack  in  1  consumer accepts the element.
- busy  out  1  high in MAC or OUT.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs and the accumulator go to 0. Takes effect mid-operation too; the partial result is discarded and no z_stb is issued.
- States are IDLE, MAC, OUT, DONE.
- IDLE:
  - When start=1: i=j=k=0 and acc=0, then go to MAC.
- MAC:
  - Index outputs are driven as a_i=i, a_j=k, b_i=k, b_j=j.
  - On each edge, acc += sext(a_in)*sext(b_in), with signed two's-complement arithmetic at AW bits. The accumulator never overflows.
  - k increments. When k==K-1, go to OUT and set k=0.
  - K=1 gives a single MAC cycle.
- OUT:
  - z_stb=1, z_i=i, z_j=j, z_out=reduce(acc).
  - Outputs hold stable until the transfer. A transfer is any rising edge with z_stb=1 and z_ack=1.
  - On transfer, z_stb=0. Then:
    - If j<N-1: j++.
    - Else if i<M-1: j=0 and i++.
    - Else go to DONE.
  - If not going to DONE: acc=0 and go to MAC.
  - z_ack is ignored while z_stb=0; stale or extra ack pulses are harmless.
- Latency: K cycles of MAC plus at least 1 OUT cycle per element. With a registered ack (ack arrives 1 cycle after stb), each element takes K+2 cycles.
- DONE:
  - done=1 and busy=0.
  - Return to IDLE only when start=0. A held start therefore never triggers a restart.
- start while busy is ignored.
- reduce() in the default build: wrap, taking the low DW bits of acc.
- Index outputs beyond their dimension are never driven. In IDLE and DONE they are 0.

Optional Feature:
- Macro: PARAM_MATRIX_MULTIPLIER_SAT_EN.
- Defined: reduce() saturates acc to the signed DW range [-2^(DW-1), 2^(DW-1)-1].
- Undefined: reduce() wraps (truncation). Cycle timing is identical in both builds.

Decomposition:
- Shared package/include matmul_pkg: state encodings (IDLE/MAC/OUT/DONE), the index-width function and the accumulator-width function.
- One natural sub-module, matmul_mac_unit:
  - Signed multiply-accumulate with a clear input and an accumulate-enable input.
  - Contains the reduce() logic, i.e. the SAT_EN-dependent saturation or wrap.
- The FSM and index counters stay in the top module.

Test Plan:
- M=K=N=4, DW=32, A=identity, B[i][j]=4i+j, registered ack -> 16 strobes in row-major order with z_out=4i+j, then done=1.
- M=2,K=3,N=2, A=[[1,2,3],[4,5,6]], B=[[7,8],[9,10],[11,12]] -> Z=[[58,64],[139,154]] with z_i/z_j correct.
- DW=8, M=1,K=2,N=1:
  - A=[100,100], B=[100,100] -> 0x20 by default; 0x7F with SAT_EN.
  - A=[-100,-100], same B -> 0xE0 by default; 0x80 with SAT_EN.
- Ack delayed 5 cycles on element (1,2) -> z_stb, z_out and z_i/z_j held stable throughout; no index advance; a stray ack while z_stb=0 has no effect.
- rst=0 pulsed during the third MAC cycle of element (0,1) -> all outputs 0 immediately; with start=1 held, the bench restarts and produces the correct full result from (0,0).
- start held high after done -> done stays high, no new strobes; dropping start -> IDLE; raising start again -> a new full computation.
